uart_tx_nedge: RTL and testbench
================================

Name: uart_tx_nedge

Overview:
- Serial frame transmitter (UART-style). It takes a parallel word through a valid/ready handshake and shifts it out on one line: start bit, data LSB-first, optional parity, stop bit(s).
- All state updates on the falling edge of clk, matching the negative-edge flip-flop family it is built from.
- Pairs with the serial receiver / testbench-side deserializer; sits between a byte producer and an off-block serial line.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 4, clk cycles per serial bit (>=1).
- PARITY_EN, 0, 1 inserts a parity bit after the data.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  clock; all registers update on negedge clk.
- rst_n  input  1  synchronous active-low reset, sampled on negedge clk.
- tx_data  input  DATA_W  word to send; sampled only at handshake.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word (registered).
- tx  output  1  serial line; idle/stop level 1 (registered).
- tx_busy  output  1  frame in progress (registered, equals ~tx_ready).

Behaviour:
- Reset (rst_n=0 at a falling edge):
  - outputs become tx=1, tx_ready=1, tx_busy=0;
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP. Each bit is held for exactly CLKS_PER_BIT cycles; a cycle counter runs 0..CLKS_PER_BIT-1.
- IDLE: tx=1, tx_ready=1.
  - Handshake is tx_valid=1 while tx_ready=1 at a falling edge (edge N).
  - At edge N: latch tx_data into the shift register, compute the parity bit, go to START.
  - Also at edge N: tx=0, tx_ready=0, tx_busy=1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with tx=data[0].
- DATA: tx=shift[0]; shift right each bit period; DATA_W bits, LSB first.
  - After the last bit: go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = ^data when PARITY_ODD=0, or ~^data when PARITY_ODD=1; held for one bit period.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the last STOP cycle's edge: go to IDLE with tx_ready=1, tx_busy=0.
- Frame length F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
  - tx_ready returns to 1 at edge N+F.
- Back-to-back: if tx_valid=1 at edge N+F, the next frame is accepted at that edge and its start bit follows the stop bit with zero idle gap.
- tx_valid and tx_data are ignored while tx_ready=0. Changing tx_data mid-frame has no effect on the line.
- tx_valid dropping mid-frame does not abort the frame.
- CLKS_PER_BIT=1: one cycle per bit; there is no special case.
- Reset mid-frame: at that falling edge tx=1 and state=IDLE. The partial frame is abandoned; no stop bit is appended.
- rst_n and tx_valid both active at the same edge: reset wins and no word is accepted.
- Nothing changes on the rising edge of clk. Outputs are glitch-free (driven only from registers).

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, no parity; send 0xA5.
  - Required: tx holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
  - tx_ready is low for exactly 40 cycles, then high.
- PARITY_EN=1; send 0xA5 with PARITY_ODD=0, then with PARITY_ODD=1.
  - Required: parity bit = 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1, in the 9th bit slot.
  - Frame = 44 cycles.
- Back-to-back: hold tx_valid=1 with 0x00, then switch to 0xFF at the second handshake.
  - Required: stop bit of frame 1 is immediately followed by the start bit of frame 2.
  - There are no idle cycles; the second frame's data bits are all 1.
- Mid-frame data change: change tx_data to 0x3C during the DATA state of a 0xA5 frame.
  - Required: the line still carries 0xA5. The new value is sent only after a new handshake.
- Reset mid-frame: assert rst_n=0 for one edge during bit 3 of the data.
  - Required: tx=1, tx_ready=1 at that edge; no further frame activity.
  - The next handshake produces a clean full frame.
- Random stimulus: send 10 words from $random with CLKS_PER_BIT=1 and with CLKS_PER_BIT=4, STOP_BITS=2.
  - A bench deserializer samples mid-bit.
  - Required: every decoded word equals the word sent, and every stop bit reads 1.

Source files
------------

// File: rtl/uart_tx_nedge.sv
// UART-style frame transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// All state lives in negative-edge flops; outputs come straight from registers.
module uart_tx_nedge #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy
);

  localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CycW       = $clog2(StopCycles + 1);
  localparam int unsigned BitW       = $clog2(DATA_W + 1);

  localparam logic [CycW-1:0] BitLast  = CycW'(CLKS_PER_BIT - 1);
  localparam logic [CycW-1:0] StopLast = CycW'(StopCycles - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              bit_done;

  assign bit_done = (cyc_q == BitLast);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_valid) accept = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          cyc_d = '0;
          if (bit_q == DataLast) begin
            if (PARITY_EN) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          cyc_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StStop: begin
        if (cyc_q == StopLast) begin
          // A waiting word starts right here so the next start bit abuts this stop bit.
          if (tx_valid) begin
            accept = 1'b1;
          end else begin
            state_d = StIdle;
            cyc_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      state_d = StStart;
      cyc_d   = '0;
      bit_d   = '0;
      shift_d = tx_data;
      par_d   = (^tx_data) ^ PARITY_ODD;
      tx_d    = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_nedge.sv
// Bench for uart_tx_nedge: five parameter variants, each line compared against a
// slot-level frame model and a mid-bit deserializer.
module tb_uart_tx_nedge;

  localparam int NInst = 5;
  // Per-instance configuration: default, even parity, odd parity, 1 clk/bit, 2 stop bits.
  localparam int CpbCfg  [NInst] = '{4, 4, 4, 1, 4};
  localparam bit PeCfg   [NInst] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit PoCfg   [NInst] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam int StopCfg [NInst] = '{1, 1, 1, 1, 2};

  logic       clk;
  logic       rst_n;
  logic [7:0] data_v  [NInst];
  logic       valid_v [NInst];
  logic       tx_v    [NInst];
  logic       ready_v [NInst];
  logic       busy_v  [NInst];

  int tests;
  int fails;

  uart_tx_nedge #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                  .STOP_BITS(1)) u_base (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]));

  uart_tx_nedge #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
                  .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]));

  uart_tx_nedge #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
                  .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]));

  uart_tx_nedge #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                  .STOP_BITS(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[3]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]));

  uart_tx_nedge #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                  .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[4]), .tx_valid(valid_v[4]),
    .tx_ready(ready_v[4]), .tx(tx_v[4]), .tx_busy(busy_v[4]));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // DUT state changes on negedge; inputs are driven and outputs sampled just after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int idx);
    return (1 + 8 + int'(PeCfg[idx]) + StopCfg[idx]) * CpbCfg[idx];
  endfunction

  // Line level expected at cycle i of a frame, derived from the bit-slot layout.
  function automatic logic exp_level(input int idx, input logic [7:0] w, input int i);
    int slot;
    slot = i / CpbCfg[idx];
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (PeCfg[idx] && slot == 9) return logic'(($countones(w) % 2) == 1) ^ PoCfg[idx];
    return 1'b1;
  endfunction

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (ready_v[idx] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("ready_timeout", ready_v[idx], 1'b1);
  endtask

  // Checks ncyc cycles (0 = whole frame) starting at the first cycle after the handshake edge.
  task automatic run_frame(input int idx, input logic [7:0] w, input int ncyc,
                           input int chg_at, input logic [7:0] chg_val);
    int n;
    n = (ncyc == 0) ? frame_len(idx) : ncyc;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) data_v[idx] = chg_val;
      check("line", tx_v[idx], exp_level(idx, w, i));
      check("ready_low", ready_v[idx], 1'b0);
      check("busy_high", busy_v[idx], 1'b1);
      step();
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check({tag, "_tx"}, tx_v[idx], 1'b1);
    check({tag, "_ready"}, ready_v[idx], 1'b1);
    check({tag, "_busy"}, busy_v[idx], 1'b0);
  endtask

  task automatic handshake(input int idx, input logic [7:0] w);
    wait_ready(idx);
    valid_v[idx] = 1'b1;
    data_v[idx]  = w;
    step();
    valid_v[idx] = 1'b0;
  endtask

  // Independent receiver: one sample per bit, taken mid-bit.
  task automatic decode_frame(input int idx, input logic [7:0] sent);
    int   c;
    int   f;
    logic slots [12];
    logic [7:0] got;
    c = CpbCfg[idx];
    f = frame_len(idx);
    for (int i = 0; i < f; i++) begin
      if ((i % c) == c / 2) slots[i / c] = tx_v[idx];
      step();
    end
    for (int b = 0; b < 8; b++) got[b] = slots[b+1];
    check("rx_start", slots[0], 1'b0);
    check("rx_word", got, sent);
    for (int s = 0; s < StopCfg[idx]; s++) check("rx_stop", slots[9+s], 1'b1);
    check("rx_ready_after", ready_v[idx], 1'b1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    for (int k = 0; k < NInst; k++) begin
      valid_v[k] = 1'b0;
      data_v[k]  = 8'h00;
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 0; k < NInst; k++) check_idle(k, "reset");
    step();

    // Basic 0xA5 frame, 40 cycles low ready.
    handshake(0, 8'hA5);
    run_frame(0, 8'hA5, 0, -1, 8'h00);
    check_idle(0, "a5_end");

    // Parity variants: even -> parity 0, odd -> parity 1 for 0xA5.
    handshake(1, 8'hA5);
    for (int i = 0; i < 44; i++) begin
      if (i == 38) check("par_even_slot", tx_v[1], 1'b0);
      check("par_even_line", tx_v[1], exp_level(1, 8'hA5, i));
      step();
    end
    check_idle(1, "par_even_end");
    handshake(2, 8'hA5);
    for (int i = 0; i < 44; i++) begin
      if (i == 38) check("par_odd_slot", tx_v[2], 1'b1);
      check("par_odd_line", tx_v[2], exp_level(2, 8'hA5, i));
      step();
    end
    check_idle(2, "par_odd_end");

    // Back-to-back: valid held high, data switched to 0xFF while frame 1 runs.
    wait_ready(0);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h00;
    step();
    run_frame(0, 8'h00, 0, 0, 8'hFF);
    valid_v[0] = 1'b0;
    run_frame(0, 8'hFF, 0, -1, 8'h00);
    check_idle(0, "b2b_end");

    // Data change during DATA state has no effect; 0x3C goes out only after its own handshake.
    handshake(0, 8'hA5);
    run_frame(0, 8'hA5, 0, 14, 8'h3C);
    check_idle(0, "chg_end");
    repeat (3) begin
      check("chg_no_frame", tx_v[0], 1'b1);
      step();
    end
    handshake(0, 8'h3C);
    run_frame(0, 8'h3C, 0, -1, 8'h00);

    // Reset during data bit 3 abandons the frame.
    handshake(0, 8'hA5);
    run_frame(0, 8'hA5, 18, -1, 8'h00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle(0, "midrst");
    for (int i = 0; i < 50; i++) begin
      check("midrst_quiet", tx_v[0], 1'b1);
      step();
    end
    handshake(0, 8'hA5);
    run_frame(0, 8'hA5, 0, -1, 8'h00);
    check_idle(0, "post_rst");

    // Reset and valid at the same edge: reset wins.
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h81;
    rst_n      = 1'b0;
    step();
    rst_n      = 1'b1;
    valid_v[0] = 1'b0;
    check_idle(0, "rst_vs_valid");
    step();
    check_idle(0, "rst_vs_valid_after");

    // Random words through the 1 clk/bit and 2-stop-bit variants.
    for (int k = 0; k < 10; k++) begin
      logic [7:0] w;
      w = 8'($urandom);
      handshake(3, w);
      decode_frame(3, w);
      repeat ($urandom_range(0, 3)) step();
    end
    for (int k = 0; k < 10; k++) begin
      logic [7:0] w;
      w = 8'($urandom);
      handshake(4, w);
      decode_frame(4, w);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
